// File: rtl/fu0_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fu0_wb_buffer
// Description : Two-entry in-order writeback buffer for FU0 results with
//               branch-mask tracking. A mispredicted branch squashes every
//               entry (and any incoming packet) tagged with it. A correctly
//               predicted branch clears its bit in every mask.
//               Optional feature macro: FU0_WB_BYPASS_EN. When it is defined,
//               a packet arriving at an empty buffer while writeback is ready
//               goes straight to the output in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fu0_wb_buffer #(
    parameter int CHECKPOINTS     = 4,
    parameter int CHECKPOINTS_LOG = 2,
    parameter int PAYLOAD_W       = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHECKPOINTS+PAYLOAD_W-1:0] fuPacket_i,
    input  logic                             fuValid_i,
    output logic                             fuReady_o,
    input  logic                             ctrlVerified_i,
    input  logic                             ctrlMispredict_i,
    input  logic [CHECKPOINTS_LOG-1:0]       ctrlSMTid_i,
    output logic [CHECKPOINTS+PAYLOAD_W-1:0] wbPacket_o,
    output logic                             wbValid_o,
    input  logic                             wbReady_i
);

    localparam int c_PKT_W = CHECKPOINTS + PAYLOAD_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_head_valid;
    logic                 r_tail_valid;
    logic [c_PKT_W-1:0]   r_head;
    logic [c_PKT_W-1:0]   r_tail;
    logic [c_PKT_W-1:0]   w_next_head;
    logic [c_PKT_W-1:0]   w_next_tail;

    logic                 w_mispredict;
    logic                 w_correct;
    logic                 w_head_live;
    logic                 w_tail_live;
    logic                 w_in_accept;
    logic                 w_bypass;
    logic                 w_deq;
    logic                 w_store_in;
    logic                 w_keep_head;
    logic [c_PKT_W-1:0]   w_in_pkt;
    logic [c_PKT_W-1:0]   w_head_upd;
    logic [c_PKT_W-1:0]   w_tail_upd;

    // True when the packet's mask carries the resolving branch's tag.
    function automatic logic tag_hit(input logic [c_PKT_W-1:0] pkt,
                                     input logic [CHECKPOINTS_LOG-1:0] tag);
        logic [CHECKPOINTS-1:0] m;
        m = pkt[PAYLOAD_W +: CHECKPOINTS];
        return m[tag];
    endfunction

    // Clears the resolved branch's bit in the mask; payload is untouched.
    function automatic logic [c_PKT_W-1:0] clear_tag(input logic [c_PKT_W-1:0] pkt,
                                                     input logic en,
                                                     input logic [CHECKPOINTS_LOG-1:0] tag);
        logic [CHECKPOINTS-1:0] m;
        m = pkt[PAYLOAD_W +: CHECKPOINTS];
        if (en) begin
            m[tag] = 1'b0;
        end
        return {m, pkt[PAYLOAD_W-1:0]};
    endfunction

    // Readiness depends only on registered occupancy (and is held low in reset).
    assign fuReady_o = ~reset & (r_state != ST_FULL);

    // Squash, accept, bypass and dequeue decisions plus the compacted next state.
    always_comb begin
        w_mispredict = ctrlVerified_i & ctrlMispredict_i;
        w_correct    = ctrlVerified_i & ~ctrlMispredict_i;

        // Squash takes priority over both enqueue and dequeue.
        w_head_live  = r_head_valid & ~(w_mispredict & tag_hit(r_head, ctrlSMTid_i));
        w_tail_live  = r_tail_valid & ~(w_mispredict & tag_hit(r_tail, ctrlSMTid_i));
        w_in_accept  = fuValid_i & fuReady_o & ~(w_mispredict & tag_hit(fuPacket_i, ctrlSMTid_i));

        w_in_pkt     = clear_tag(fuPacket_i, w_correct, ctrlSMTid_i);
        w_head_upd   = clear_tag(r_head, w_correct, ctrlSMTid_i);
        w_tail_upd   = clear_tag(r_tail, w_correct, ctrlSMTid_i);

`ifdef FU0_WB_BYPASS_EN
        w_bypass     = w_in_accept & (r_state == ST_EMPTY) & wbReady_i;
`else
        w_bypass     = 1'b0;
`endif

        wbValid_o    = w_head_live | w_bypass;
        wbPacket_o   = w_bypass ? w_in_pkt : r_head;

        w_deq        = w_head_live & wbReady_i;
        w_store_in   = w_in_accept & ~w_bypass;
        w_keep_head  = w_head_live & ~w_deq;

        // Compaction: survivors fill head first, then tail, preserving order.
        // FULL never accepts, so at most two survivors can exist.
        w_next_state = ST_EMPTY;
        w_next_head  = r_head;
        w_next_tail  = r_tail;
        if (w_keep_head) begin
            w_next_head = w_head_upd;
            if (w_tail_live) begin
                w_next_tail  = w_tail_upd;
                w_next_state = ST_FULL;
            end else if (w_store_in) begin
                w_next_tail  = w_in_pkt;
                w_next_state = ST_FULL;
            end else begin
                w_next_state = ST_ONE;
            end
        end else if (w_tail_live) begin
            w_next_head = w_tail_upd;
            if (w_store_in) begin
                w_next_tail  = w_in_pkt;
                w_next_state = ST_FULL;
            end else begin
                w_next_state = ST_ONE;
            end
        end else if (w_store_in) begin
            w_next_head  = w_in_pkt;
            w_next_state = ST_ONE;
        end
    end

    // Occupancy state, valid bits and entry storage; reset discards everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_EMPTY;
            r_head_valid <= 1'b0;
            r_tail_valid <= 1'b0;
            r_head       <= '0;
            r_tail       <= '0;
        end else begin
            r_state      <= w_next_state;
            r_head_valid <= (w_next_state != ST_EMPTY);
            r_tail_valid <= (w_next_state == ST_FULL);
            r_head       <= w_next_head;
            r_tail       <= w_next_tail;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fu0_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fu0_wb_buffer
// Description : Directed self-checking bench for fu0_wb_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fu0_wb_buffer;

    localparam int c_PKT_W = 68;

    logic               clk;
    logic               reset;
    logic [c_PKT_W-1:0] fuPacket_i;
    logic               fuValid_i;
    logic               fuReady_o;
    logic               ctrlVerified_i;
    logic               ctrlMispredict_i;
    logic [1:0]         ctrlSMTid_i;
    logic [c_PKT_W-1:0] wbPacket_o;
    logic               wbValid_o;
    logic               wbReady_i;

    int errors = 0;
    int checks = 0;

    fu0_wb_buffer #(
        .CHECKPOINTS     (4),
        .CHECKPOINTS_LOG (2),
        .PAYLOAD_W       (64)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fuPacket_i       (fuPacket_i),
        .fuValid_i        (fuValid_i),
        .fuReady_o        (fuReady_o),
        .ctrlVerified_i   (ctrlVerified_i),
        .ctrlMispredict_i (ctrlMispredict_i),
        .ctrlSMTid_i      (ctrlSMTid_i),
        .wbPacket_o       (wbPacket_o),
        .wbValid_o        (wbValid_o),
        .wbReady_i        (wbReady_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [c_PKT_W-1:0] pk(input logic [3:0] m, input logic [63:0] p);
        return {m, p};
    endfunction

    task automatic chk(input string tag, input logic [c_PKT_W-1:0] obs, input logic [c_PKT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic v, input logic m, input logic [1:0] t);
        ctrlVerified_i   = v;
        ctrlMispredict_i = m;
        ctrlSMTid_i      = t;
    endtask

    initial begin
        int sent;
        int got;
        reset = 1'b1;
        fuPacket_i = '0;
        fuValid_i = 1'b0;
        wbReady_i = 1'b0;
        ctrl(1'b0, 1'b0, 2'd0);
        tick();
        tick();

        // Reset state
        chk("rst_fuReady", fuReady_o, 0);
        chk("rst_wbValid", wbValid_o, 0);
        chk("rst_wbPacket", wbPacket_o, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_fuReady", fuReady_o, 1);

        // Latency from EMPTY: bypass is same-cycle, otherwise one cycle later
        wbReady_i = 1'b1;
        fuValid_i = 1'b1;
        fuPacket_i = pk(4'b0000, 64'hA5);
        #1;
`ifdef FU0_WB_BYPASS_EN
        chk("byp_same_valid", wbValid_o, 1);
        chk("byp_same_pkt", wbPacket_o, pk(4'b0000, 64'hA5));
        tick();
        fuValid_i = 1'b0;
        #1;
        chk("byp_next_valid", wbValid_o, 0);
`else
        chk("lat_same_valid", wbValid_o, 0);
        tick();
        fuValid_i = 1'b0;
        #1;
        chk("lat_next_valid", wbValid_o, 1);
        chk("lat_next_pkt", wbPacket_o, pk(4'b0000, 64'hA5));
`endif
        tick();
        chk("lat_drained", wbValid_o, 0);

        // Fill to FULL with writeback stalled
        wbReady_i = 1'b0;
        fuValid_i = 1'b1;
        fuPacket_i = pk(4'b0001, 64'h11);
        tick();
        fuPacket_i = pk(4'b0010, 64'h22);
        tick();
        fuPacket_i = pk(4'b0000, 64'h33);
        #1;
        chk("full_fuReady", fuReady_o, 0);
        chk("full_head", wbPacket_o, pk(4'b0001, 64'h11));
        tick();
        fuValid_i = 1'b0;
        #1;
        chk("held_head", wbPacket_o, pk(4'b0001, 64'h11));
        chk("held_fuReady", fuReady_o, 0);

        // Mispredict tag 0 squashes the head; tail moves up
        ctrl(1'b1, 1'b1, 2'd0);
        #1;
        chk("sq_forced_valid", wbValid_o, 0);
        tick();
        ctrl(1'b0, 1'b0, 2'd0);
        #1;
        chk("sq_tail_valid", wbValid_o, 1);
        chk("sq_tail_pkt", wbPacket_o, pk(4'b0010, 64'h22));
        chk("sq_one_ready", fuReady_o, 1);
        wbReady_i = 1'b1;
        tick();
        chk("sq_drained", wbValid_o, 0);

        // Correct prediction on tag 1 clears that mask bit only
        wbReady_i = 1'b0;
        fuValid_i = 1'b1;
        fuPacket_i = pk(4'b0011, 64'h55);
        tick();
        fuValid_i = 1'b0;
        ctrl(1'b1, 1'b0, 2'd1);
        tick();
        ctrl(1'b0, 1'b0, 2'd0);
        #1;
        chk("cp_mask_cleared", wbPacket_o, pk(4'b0001, 64'h55));

        // ONE with simultaneous enqueue and dequeue stays ONE
        wbReady_i = 1'b1;
        fuValid_i = 1'b1;
        fuPacket_i = pk(4'b0000, 64'h66);
        tick();
        fuValid_i = 1'b0;
        wbReady_i = 1'b0;
        #1;
        chk("one_swap_pkt", wbPacket_o, pk(4'b0000, 64'h66));
        chk("one_swap_ready", fuReady_o, 1);
        fuValid_i = 1'b1;
        fuPacket_i = pk(4'b0000, 64'h77);
        tick();
        fuValid_i = 1'b0;
        #1;
        chk("one_then_full", fuReady_o, 0);
        wbReady_i = 1'b1;
        tick();
        chk("drain_order", wbPacket_o, pk(4'b0000, 64'h77));
        tick();
        chk("drain_empty", wbValid_o, 0);

        // Incoming packet squashed by a same-cycle mispredict
        wbReady_i = 1'b0;
        fuValid_i = 1'b1;
        fuPacket_i = pk(4'b0100, 64'h99);
        ctrl(1'b1, 1'b1, 2'd2);
        tick();
        ctrl(1'b0, 1'b0, 2'd0);
        fuValid_i = 1'b0;
        #1;
        chk("in_squash_valid", wbValid_o, 0);

        // Incoming packet mask cleared by a same-cycle correct prediction
        fuValid_i = 1'b1;
        fuPacket_i = pk(4'b0110, 64'hAA);
        ctrl(1'b1, 1'b0, 2'd1);
        tick();
        ctrl(1'b0, 1'b0, 2'd0);
        fuValid_i = 1'b0;
        #1;
        chk("in_clear_pkt", wbPacket_o, pk(4'b0100, 64'hAA));
        wbReady_i = 1'b1;
        tick();

        // Back-to-back stream of 10 packets
        sent = 0;
        got = 0;
        for (int c = 0; c < 30 && got < 10; c++) begin
            fuValid_i = (sent < 10);
            fuPacket_i = pk(4'b0000, 64'h100 + 64'(sent));
            #1;
            if (wbValid_o) begin
                chk("stream_order", wbPacket_o, pk(4'b0000, 64'h100 + 64'(got)));
                got++;
            end
            if (fuValid_i && fuReady_o) sent++;
            tick();
        end
        fuValid_i = 1'b0;
        chk("stream_count", 32'(got), 10);

        // Reset asserted while FULL
        wbReady_i = 1'b0;
        fuValid_i = 1'b1;
        fuPacket_i = pk(4'b0000, 64'hC1);
        tick();
        fuPacket_i = pk(4'b0000, 64'hC2);
        tick();
        fuValid_i = 1'b0;
        #1;
        chk("pre_rst_full", fuReady_o, 0);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", wbValid_o, 0);
        chk("mid_rst_ready", fuReady_o, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rel_ready", fuReady_o, 1);
        tick();
        chk("rel_valid", wbValid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
